snake_dir_ctrl: RTL and testbench

Consumes the registered key codes from the keyboard debouncer and turns them into game control for the snake core. It decodes direction, start, pause and quit keys, and runs the game-mode FSM (MENU/RUN/PAUSE/OVER). It buffers pending turns in a small queue so that fast key sequences are honoured one per game tick. A 180° reversal is never allowed.

---
 rtl/snake_pkg.sv | 40 ++++
 rtl/dir_queue.sv | 75 +++++++
 rtl/snake_dir_ctrl.sv | 147 ++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game control path.
//   dir_e  : movement direction as presented on snake_dir_ctrl.dir
//   mode_e : game mode as presented on snake_dir_ctrl.mode
//   KEY_*  : ASCII codes delivered by the keyboard debouncer
//   is_reversal() : true when two directions point opposite ways
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirRight = 2'd1,
        DirDown  = 2'd2,
        DirLeft  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ModeMenu  = 2'd0,
        ModeRun   = 2'd1,
        ModePause = 2'd2,
        ModeOver  = 2'd3
    } mode_e;

    localparam logic [7:0] KEY_W_LO  = 8'h77;
    localparam logic [7:0] KEY_W_UP  = 8'h57;
    localparam logic [7:0] KEY_A_LO  = 8'h61;
    localparam logic [7:0] KEY_A_UP  = 8'h41;
    localparam logic [7:0] KEY_S_LO  = 8'h73;
    localparam logic [7:0] KEY_S_UP  = 8'h53;
    localparam logic [7:0] KEY_D_LO  = 8'h64;
    localparam logic [7:0] KEY_D_UP  = 8'h44;
    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_P_LO  = 8'h70;
    localparam logic [7:0] KEY_P_UP  = 8'h50;
    localparam logic [7:0] KEY_ESC   = 8'h1B;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
        return a == (b ^ 2'd2);
    endfunction

endpackage

// File: rtl/dir_queue.sv
// Small synchronous FIFO of 2-bit directions holding pending turns.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full unless popping too)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the queue; overrides push and pop
//   head, tail : oldest and newest entry (undefined content when empty)
//   empty, full: occupancy flags
module dir_queue #(
    parameter int unsigned Depth = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic       empty,
    output logic       full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [1:0]      mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] tail_ptr;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntW'(Depth));
        do_pop   = pop && !empty;
        // A full queue still accepts a write when the head leaves the same cycle.
        do_push  = push && (!full || do_pop);
        tail_ptr = (wr_ptr_q == '0) ? LastPtr : wr_ptr_q - PtrW'(1);
        head     = mem_q[rd_ptr_q];
        tail     = mem_q[tail_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Keyboard-to-game control for the snake core: key edge detection, key
// decoding, game-mode FSM and a queue of pending turns drained one per tick.
//   clk, rst_n : system clock, asynchronous active-low reset
//   key_data   : ASCII code from the debouncer, 8'h00 = no key
//   game_tick  : one-cycle pulse, snake advances one cell
//   game_over  : one-cycle collision pulse (only honoured in RUN)
//   dir        : current direction (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT)
//   step       : registered tick, only while in RUN
//   restart    : one-cycle pulse on entering RUN from MENU or OVER
//   mode       : 0 MENU, 1 RUN, 2 PAUSE, 3 OVER
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [1:0]  START_DIR   = 2'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_data,
    input  logic       game_tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       step,
    output logic       restart,
    output logic [1:0] mode
);

    logic [7:0] key_prev_q;
    logic       key_event;
    logic       is_dir;
    logic [1:0] key_dir;
    logic       is_enter;
    logic       is_pause;
    logic       is_esc;

    mode_e      mode_q;
    logic [1:0] dir_q;
    logic       step_q;
    logic       restart_q;

    logic       run;
    logic       go_over;
    logic       go_menu;
    logic       go_pause;
    logic       go_resume;
    logic       go_restart;

    logic       q_push;
    logic       q_pop;
    logic       q_flush;
    logic [1:0] q_head;
    logic [1:0] q_tail;
    logic       q_empty;
    logic       q_full;
    logic [1:0] ref_dir;

    // Only a zero-to-nonzero change counts, so a held key fires once.
    assign key_event = (key_data != 8'h00) && (key_prev_q == 8'h00);

    always_comb begin
        is_dir   = 1'b0;
        key_dir  = DirUp;
        is_enter = 1'b0;
        is_pause = 1'b0;
        is_esc   = 1'b0;
        case (key_data)
            KEY_W_LO, KEY_W_UP: begin is_dir = 1'b1; key_dir = DirUp;    end
            KEY_D_LO, KEY_D_UP: begin is_dir = 1'b1; key_dir = DirRight; end
            KEY_S_LO, KEY_S_UP: begin is_dir = 1'b1; key_dir = DirDown;  end
            KEY_A_LO, KEY_A_UP: begin is_dir = 1'b1; key_dir = DirLeft;  end
            KEY_ENTER:          is_enter = 1'b1;
            KEY_P_LO, KEY_P_UP: is_pause = 1'b1;
            KEY_ESC:            is_esc   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        run        = (mode_q == ModeRun);
        go_over    = run && game_over;
        // game_over outranks any key arriving in the same cycle.
        go_menu    = key_event && is_esc && (mode_q != ModeMenu) && !go_over;
        go_pause   = key_event && is_pause && run && !go_over;
        go_resume  = key_event && is_pause && (mode_q == ModePause);
        go_restart = key_event && is_enter && ((mode_q == ModeMenu) || (mode_q == ModeOver));
    end

    // Turns are checked against the newest queued turn, not the current heading.
    always_comb begin
        ref_dir = q_empty ? dir_q : q_tail;
        q_push  = key_event && is_dir && run &&
                  (key_dir != ref_dir) && !is_reversal(key_dir, ref_dir);
        q_pop   = game_tick && run && !q_empty;
        q_flush = go_restart || go_menu;
    end

    dir_queue #(
        .Depth (QUEUE_DEPTH)
    ) u_dir_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (key_dir),
        .head  (q_head),
        .tail  (q_tail),
        .empty (q_empty),
        .full  (q_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev_q <= 8'h00;
            mode_q     <= ModeMenu;
            dir_q      <= START_DIR;
            step_q     <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            key_prev_q <= key_data;
            step_q     <= game_tick && run;
            restart_q  <= go_restart;

            if (go_restart) begin
                dir_q <= START_DIR;
            end else if (q_pop) begin
                dir_q <= q_head;
            end

            if (go_over) begin
                mode_q <= ModeOver;
            end else if (go_menu) begin
                mode_q <= ModeMenu;
            end else if (go_restart || go_resume) begin
                mode_q <= ModeRun;
            end else if (go_pause) begin
                mode_q <= ModePause;
            end
        end
    end

    assign dir     = dir_q;
    assign step    = step_q;
    assign restart = restart_q;
    assign mode    = mode_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_data;
    logic       game_tick;
    logic       game_over;
    logic [1:0] dir;
    logic       step;
    logic       restart;
    logic [1:0] mode;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] key;
        logic       tick;
        logic       gover;
        logic [1:0] exp_mode;
        logic [1:0] exp_dir;
        logic       exp_step;
        logic       exp_restart;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    snake_dir_ctrl #(
        .QUEUE_DEPTH (2),
        .START_DIR   (2'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_data  (key_data),
        .game_tick (game_tick),
        .game_over (game_over),
        .dir       (dir),
        .step      (step),
        .restart   (restart),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic [7:0] k, input logic t, input logic g,
                               input logic [1:0] m, input logic [1:0] d,
                               input logic s, input logic r);
        vec_t x;
        x.key = k; x.tick = t; x.gover = g;
        x.exp_mode = m; x.exp_dir = d; x.exp_step = s; x.exp_restart = r;
        return x;
    endfunction

    // Compared word is {mode, dir, step, restart}.
    task automatic check(input string name, input int idx, input logic [5:0] act,
                         input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] mode/dir/step/restart got=%b_%b_%b_%b want=%b_%b_%b_%b",
                     name, idx, act[5:4], act[3:2], act[1], act[0],
                     exp[5:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input logic [7:0] k, input logic t, input logic g);
        @(negedge clk);
        key_data  = k;
        game_tick = t;
        game_over = g;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            apply(tbl[i].key, tbl[i].tick, tbl[i].gover);
            check(name, i, {mode, dir, step, restart},
                  {tbl[i].exp_mode, tbl[i].exp_dir, tbl[i].exp_step, tbl[i].exp_restart});
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_data  = 8'h00;
        game_tick = 1'b0;
        game_over = 1'b0;

        // key, tick, game_over -> mode, dir, step, restart
        // Menu, enter, dropped reversal, two queued turns
        tbl1.push_back(v(8'h00, 0, 0, 2'd0, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd0, 2'd1, 0, 0));
        tbl1.push_back(v(8'h0D, 0, 0, 2'd1, 2'd1, 0, 1));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h61, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd1, 1, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h77, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h61, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd0, 1, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd3, 1, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd3, 1, 0));
        // Esc to menu, game_over ignored in menu, restart brings dir back to RIGHT
        tbl1.push_back(v(8'h1B, 0, 0, 2'd0, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 0, 1, 2'd0, 2'd3, 0, 0));
        tbl1.push_back(v(8'h0D, 0, 0, 2'd1, 2'd1, 0, 1));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        // Overflow: w, a accepted; s, d dropped
        tbl1.push_back(v(8'h77, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h61, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h73, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h64, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd0, 1, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd3, 1, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd3, 1, 0));
        // Pause keeps queue, ignores ticks and direction keys
        tbl1.push_back(v(8'h77, 0, 0, 2'd1, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd3, 0, 0));
        tbl1.push_back(v(8'h70, 0, 0, 2'd2, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd2, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd2, 2'd3, 0, 0));
        tbl1.push_back(v(8'h64, 0, 0, 2'd2, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd2, 2'd3, 0, 0));
        tbl1.push_back(v(8'h50, 0, 0, 2'd1, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd3, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd0, 1, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd0, 1, 0));
        // Turn LEFT to set up the held-key case
        tbl1.push_back(v(8'h41, 0, 0, 2'd1, 2'd0, 0, 0));
        tbl1.push_back(v(8'h00, 0, 0, 2'd1, 2'd0, 0, 0));
        tbl1.push_back(v(8'h00, 1, 0, 2'd1, 2'd3, 1, 0));

        // After the held key: dir=DOWN, queue empty, RUN
        tbl2.push_back(v(8'h61, 0, 0, 2'd1, 2'd2, 0, 0));
        tbl2.push_back(v(8'h00, 0, 0, 2'd1, 2'd2, 0, 0));
        tbl2.push_back(v(8'h1B, 0, 1, 2'd3, 2'd2, 0, 0));
        tbl2.push_back(v(8'h00, 1, 0, 2'd3, 2'd2, 0, 0));
        tbl2.push_back(v(8'h0D, 0, 0, 2'd1, 2'd1, 0, 1));
        tbl2.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl2.push_back(v(8'h00, 1, 0, 2'd1, 2'd1, 1, 0));
        // Key and tick together with empty queue: no bypass
        tbl2.push_back(v(8'h57, 1, 0, 2'd1, 2'd1, 1, 0));
        tbl2.push_back(v(8'h00, 0, 0, 2'd1, 2'd1, 0, 0));
        tbl2.push_back(v(8'h00, 1, 0, 2'd1, 2'd0, 1, 0));
        // Pause and tick together: step fires, then no more steps
        tbl2.push_back(v(8'h70, 1, 0, 2'd2, 2'd0, 1, 0));
        tbl2.push_back(v(8'h00, 1, 0, 2'd2, 2'd0, 0, 0));
        tbl2.push_back(v(8'h70, 0, 0, 2'd1, 2'd0, 0, 0));
        tbl2.push_back(v(8'h00, 0, 0, 2'd1, 2'd0, 0, 0));

        // Reset state, checked while reset is held and after release
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 0, {mode, dir, step, restart}, {2'd0, 2'd1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_idle", 0, {mode, dir, step, restart}, {2'd0, 2'd1, 1'b0, 1'b0});

        run_table("tbl1", tbl1);

        // Held 's' for 50 cycles with dir=LEFT: a single push only
        for (int i = 0; i < 50; i++) begin
            apply(8'h73, 0, 0);
            if (i == 0 || i == 49)
                check("held_key", i, {mode, dir, step, restart}, {2'd1, 2'd3, 1'b0, 1'b0});
        end
        apply(8'h00, 0, 0);
        apply(8'h00, 1, 0);
        check("held_tick1", 0, {mode, dir, step, restart}, {2'd1, 2'd2, 1'b1, 1'b0});
        apply(8'h00, 1, 0);
        check("held_tick2", 0, {mode, dir, step, restart}, {2'd1, 2'd2, 1'b1, 1'b0});

        run_table("tbl2", tbl2);

        // Asynchronous reset mid-run, asserted away from a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, {mode, dir, step, restart}, {2'd0, 2'd1, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h00, 1, 0);
        check("post_reset", 0, {mode, dir, step, restart}, {2'd0, 2'd1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
